tb_retire_checker: RTL
======================

# tb_retire_checker

Self-checking scoreboard downstream of the core's retirement port in the RV32 testbench. It buffers expected-result stimuli from the test generator and compares each retired instruction against the oldest buffered stimulus. It accumulates `test_stats_t` counters and runs a pass/fail/timeout state machine that ends the test.

## Interface
- `DEPTH`, 16: stimulus FIFO entries, power of two, at least 2.
- `TIMEOUT`, `tb_pkg::TIMEOUT_CYCLES`: idle cycles with no retirement before timeout.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle pulse that starts a test; latches `num_tests`.
- `num_tests` in 32: number of retirements expected, 1..`tb_pkg::MAX_TESTS`.
- `stim_valid` in 1, `stim_ready` out 1, `stim` in `tb_pkg::test_stimulus_t`: expected-stimulus stream.
- `ret_valid` in 1: the core retired an instruction this cycle.
- `ret_instr` in 32, `ret_pc` in 32, `ret_result` in 32, `ret_exception` in 1: retired instruction data.
- `done` out 1: the test has finished, sticky.
- `pass` out 1: the test passed; valid when `done`.
- `fail_code` out `tb_pkg::fail_code_e`: reason for the result.
- `fail_pc` out 32: `ret_pc` of the first failing retirement.
- `stats` out `tb_pkg::test_stats_t`: live counters.

## Operation
- States (`tb_pkg::chk_state_e`): IDLE, RUN, PASS, FAIL, TIMEOUT.
- IDLE: on `start`, go to RUN, clear `stats`, clear the idle counter, latch `num_tests`. FIFO contents are kept, so the generator may preload the FIFO before `start`.
- RUN, on each `ret_valid`:
  - Pop the FIFO head and compare `instr`, `expected_result` and `expected_exception` against the retired data.
  - Result compare is skipped when `expected_exception` is 1.
  - Any mismatch: go to FAIL with `FC_MISMATCH` and latch `fail_pc`.
- RUN, retirement when the FIFO is empty: go to FAIL with `FC_UNDERFLOW`.
- RUN: when the retired count reaches the latched `num_tests` with no failure, go to PASS. A failure on that last retirement takes priority and goes to FAIL.
- RUN: the idle counter increments on every cycle without `ret_valid` and resets to 0 on `ret_valid`. When it reaches `TIMEOUT-1`, go to TIMEOUT with `FC_TIMEOUT`.
- PASS, FAIL and TIMEOUT are terminal.
  - `ret_valid` is ignored and `stats` are frozen.
  - Only `rst` leaves these states; `start` is ignored.
- `start` while in RUN is ignored.
- Statistics, taken from the retired instruction when `ret_valid` in RUN:
  - `num_instructions` +1 on every retirement.
  - `num_branches` +1 for opcode 1100011.
  - `num_loads` +1 for opcode 0000011.
  - `num_stores` +1 for opcode 0100011.
  - `num_jumps` +1 for opcode 1101111 or 1100111.
  - `num_exceptions` +1 when `ret_exception`.
  - All counters are 32-bit and wrap modulo 2^32.
- FIFO: push on `stim_valid && stim_ready`. A stimulus is accepted in any state.

## Timing
- Reset values: state IDLE, FIFO empty, `stim_ready` 1, `done` 0, `pass` 0, `fail_code` `FC_NONE`, `fail_pc` 0, all `stats` 0.
- Reset asserted mid-test returns the block to its reset values on the next edge.
- The compare uses the combinational FIFO head. State, `stats` and `fail_*` update at the edge after `ret_valid`, so `done` asserts 1 cycle after the deciding retirement.
- `stim_ready` = `!full`, registered. Push and pop in the same cycle when full: the push is refused, the pop happens, and `stim_ready` is 1 in the following cycle.
- Push and pop in the same cycle when empty with `ret_valid`: this counts as underflow, and the pushed entry is stored.
- `pass` = (state == PASS). `done` = state is PASS, FAIL or TIMEOUT.

## Configuration
- `TB_CHECK_PC_EN` defined: `ret_pc` is also compared against `stim.pc`. A difference gives `FC_PC_MISMATCH`, which takes precedence over `FC_MISMATCH`.
- `TB_CHECK_PC_EN` undefined: `stim.pc` is stored but ignored, and `FC_PC_MISMATCH` is never produced.

## Structure
- Add to `tb_pkg`:
  - `chk_state_e`.
  - `fail_code_e`: `FC_NONE`, `FC_MISMATCH`, `FC_PC_MISMATCH`, `FC_UNDERFLOW`, `FC_TIMEOUT`.
  - Opcode constants: `OPC_BRANCH`, `OPC_LOAD`, `OPC_STORE`, `OPC_JAL`, `OPC_JALR`.
- Sub-module `tb_stim_fifo`: synchronous FIFO of `test_stimulus_t` with `DEPTH` entries. Ports: push, pop, head, full, empty.
- Pointers have log2(`DEPTH`)+1 bits, so wrap is distinguished from full.

## Test plan
- Three R-type stimuli preloaded, `start` with `num_tests`=3, three matching retirements -> PASS one cycle after the third retirement, `num_instructions`=3, other counters 0.
- Second retirement `ret_result`=0x5 against expected 0x6 at pc 0x104 -> FAIL, `FC_MISMATCH`, `fail_pc`=0x104, `num_instructions`=2.
- `ret_valid` with the FIFO empty after `start` -> FAIL, `FC_UNDERFLOW`.
- `TIMEOUT`=8, no retirement after `start` -> TIMEOUT after the 8th idle cycle, `done`=1, `pass`=0.
- `DEPTH`=4, push 5 stimuli back-to-back -> `stim_ready` low after 4. Simultaneous pop and push while full -> push refused; 5th accepted the next cycle. Retire one each of BEQ, LW, SW, JAL, JALR -> each corresponding counter correct.
- With `TB_CHECK_PC_EN`: `ret_pc`=0x200 against `stim.pc`=0x204 -> `FC_PC_MISMATCH`. Without the macro, the same stimulus -> PASS.

Source files
------------

// File: rtl/tb_pkg.sv
// Shared types and constants for the RV32 retirement scoreboard.
//   test_stimulus_t : one expected retirement from the test generator
//   test_stats_t    : live retirement counters (all 32-bit, wrapping)
//   chk_state_e     : checker state machine states
//   fail_code_e     : reason reported with the final result
//   OPC_*           : RV32 major opcodes used for statistics
package tb_pkg;

  localparam int TIMEOUT_CYCLES = 1000;
  localparam int MAX_TESTS      = 4096;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] expected_result;
    logic        expected_exception;
  } test_stimulus_t;

  typedef struct packed {
    logic [31:0] num_instructions;
    logic [31:0] num_branches;
    logic [31:0] num_loads;
    logic [31:0] num_stores;
    logic [31:0] num_jumps;
    logic [31:0] num_exceptions;
  } test_stats_t;

  typedef enum logic [2:0] {
    CHK_IDLE,
    CHK_RUN,
    CHK_PASS,
    CHK_FAIL,
    CHK_TIMEOUT
  } chk_state_e;

  typedef enum logic [2:0] {
    FC_NONE,
    FC_MISMATCH,
    FC_PC_MISMATCH,
    FC_UNDERFLOW,
    FC_TIMEOUT
  } fail_code_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/tb_retire_checker_if.sv
// Stimulus stream and retirement port between the generator/core side
// (master) and the retirement checker (slave).
//   stim_valid/stim_ready/stim : expected-stimulus handshake
//   ret_*                      : retired instruction data, qualified by ret_valid
interface tb_retire_checker_if;
  import tb_pkg::*;

  logic           stim_valid;
  logic           stim_ready;
  test_stimulus_t stim;
  logic           ret_valid;
  logic [31:0]    ret_instr;
  logic [31:0]    ret_pc;
  logic [31:0]    ret_result;
  logic           ret_exception;

  modport master (
    output stim_valid, stim, ret_valid, ret_instr, ret_pc, ret_result, ret_exception,
    input  stim_ready
  );

  modport slave (
    input  stim_valid, stim, ret_valid, ret_instr, ret_pc, ret_result, ret_exception,
    output stim_ready
  );
endinterface

// File: rtl/tb_stim_fifo.sv
// Synchronous FIFO of expected stimuli.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write request and data; ignored while full
//   pop      : read request; ignored while empty
//   head     : oldest entry, combinational (valid when !empty)
//   full, empty : status, decoded from the registered pointers
module tb_stim_fifo
  import tb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  test_stimulus_t din,
  input  logic           pop,
  output test_stimulus_t head,
  output logic           full,
  output logic           empty
);
  localparam int AW = $clog2(DEPTH);

  test_stimulus_t r_mem [DEPTH];
  // Extra MSB distinguishes "wrapped once" (full) from "equal" (empty).
  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  logic           w_push;
  logic           w_pop;

  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/tb_retire_checker.sv
// Retirement scoreboard: buffers expected stimuli and checks every retired
// instruction against the oldest one, keeping statistics and ending the test
// in PASS, FAIL or TIMEOUT.
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle pulse in IDLE, latches num_tests
//   num_tests  : retirements expected for a pass
//   chk_if     : stimulus stream + retirement port (slave side)
//   done, pass : test finished / finished with pass
//   fail_code, fail_pc : result reason and pc of the first failing retirement
//   stats      : live counters
// Optional feature: define TB_CHECK_PC_EN to also compare ret_pc with stim.pc.
module tb_retire_checker
  import tb_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          num_tests,
  tb_retire_checker_if.slave   chk_if,
  output logic                 done,
  output logic                 pass,
  output fail_code_e           fail_code,
  output logic [31:0]          fail_pc,
  output test_stats_t          stats
);
  chk_state_e     r_state;
  test_stats_t    r_stats;
  logic [31:0]    r_idle_cnt;
  logic [31:0]    r_num_tests;
  fail_code_e     r_fail_code;
  logic [31:0]    r_fail_pc;

  test_stimulus_t w_head;
  logic           w_full;
  logic           w_empty;
  logic           w_pop;
  logic           w_data_mis;
  logic           w_pc_mis;
  logic [6:0]     w_opc;
  logic [31:0]    w_next_cnt;

  assign w_pop = (r_state == CHK_RUN) && chk_if.ret_valid;

  tb_stim_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (chk_if.stim_valid),
    .din   (chk_if.stim),
    .pop   (w_pop),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign chk_if.stim_ready = !w_full;

  // Result is don't-care when an exception is expected.
  assign w_data_mis = (w_head.instr != chk_if.ret_instr) ||
                      (w_head.expected_exception != chk_if.ret_exception) ||
                      (!w_head.expected_exception &&
                       (w_head.expected_result != chk_if.ret_result));

`ifdef TB_CHECK_PC_EN
  assign w_pc_mis = (w_head.pc != chk_if.ret_pc);
`else
  logic w_unused_pc;
  assign w_unused_pc = ^w_head.pc;
  assign w_pc_mis    = 1'b0;
`endif

  assign w_opc      = opcode_of(chk_if.ret_instr);
  assign w_next_cnt = r_stats.num_instructions + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CHK_IDLE;
      r_stats     <= '0;
      r_idle_cnt  <= '0;
      r_num_tests <= '0;
      r_fail_code <= FC_NONE;
      r_fail_pc   <= '0;
    end else begin
      case (r_state)
        CHK_IDLE: begin
          if (start) begin
            r_state     <= CHK_RUN;
            r_stats     <= '0;
            r_idle_cnt  <= '0;
            r_num_tests <= num_tests;
          end
        end
        CHK_RUN: begin
          if (chk_if.ret_valid) begin
            r_idle_cnt                <= '0;
            r_stats.num_instructions  <= w_next_cnt;
            if (w_opc == OPC_BRANCH) r_stats.num_branches <= r_stats.num_branches + 32'd1;
            if (w_opc == OPC_LOAD)   r_stats.num_loads    <= r_stats.num_loads + 32'd1;
            if (w_opc == OPC_STORE)  r_stats.num_stores   <= r_stats.num_stores + 32'd1;
            if (w_opc == OPC_JAL || w_opc == OPC_JALR)
              r_stats.num_jumps <= r_stats.num_jumps + 32'd1;
            if (chk_if.ret_exception)
              r_stats.num_exceptions <= r_stats.num_exceptions + 32'd1;
            // Failure checks come before the completion check so that a bad
            // final retirement still fails.
            if (w_empty) begin
              r_state     <= CHK_FAIL;
              r_fail_code <= FC_UNDERFLOW;
              r_fail_pc   <= chk_if.ret_pc;
            end else if (w_pc_mis) begin
              r_state     <= CHK_FAIL;
              r_fail_code <= FC_PC_MISMATCH;
              r_fail_pc   <= chk_if.ret_pc;
            end else if (w_data_mis) begin
              r_state     <= CHK_FAIL;
              r_fail_code <= FC_MISMATCH;
              r_fail_pc   <= chk_if.ret_pc;
            end else if (w_next_cnt == r_num_tests) begin
              r_state <= CHK_PASS;
            end
          end else if (r_idle_cnt == 32'(TIMEOUT - 1)) begin
            r_state     <= CHK_TIMEOUT;
            r_fail_code <= FC_TIMEOUT;
          end else begin
            r_idle_cnt <= r_idle_cnt + 32'd1;
          end
        end
        default: begin
          // Terminal states: hold everything until reset.
        end
      endcase
    end
  end

  assign done      = (r_state == CHK_PASS) || (r_state == CHK_FAIL) ||
                     (r_state == CHK_TIMEOUT);
  assign pass      = (r_state == CHK_PASS);
  assign fail_code = r_fail_code;
  assign fail_pc   = r_fail_pc;
  assign stats     = r_stats;
endmodule
